// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer for the 8-bit datapath: latches operands from a 4x8 register file,
// holds them on the shared ALU for ALU_LAT cycles, then retires result and flags.
module alu_sequencer #(
  parameter int unsigned ALU_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_op,
  input  logic [7:0]  alu_result,
  input  logic        alu_v,
  input  logic        alu_c,
  input  logic        alu_n,
  input  logic        alu_z,
  output logic        done,
  output logic [3:0]  flags,
  output logic [7:0]  last_result,
  input  logic [1:0]  dbg_sel,
  output logic [7:0]  dbg_data
);

  typedef enum logic [1:0] {StIdle, StExec, StWrite} state_e;

  localparam logic [3:0] LastCnt = 4'(ALU_LAT - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [2:0] op_q, op_d;
  logic       wb_q, wb_d;
  logic [1:0] rd_q, rd_d;
  logic       done_q, done_d;
  logic [3:0] flags_q, flags_d;
  logic [7:0] last_q, last_d;
  logic [7:0] rf_q [4];
  logic [7:0] rf_d [4];

  // Reserved bit carries no meaning.
  logic unused_rsvd;
  assign unused_rsvd = instr[10];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    wb_d    = wb_q;
    rd_d    = rd_q;
    done_d  = 1'b0;
    flags_d = flags_q;
    last_d  = last_q;
    rf_d    = rf_q;
    unique case (state_q)
      StIdle: begin
        if (instr_valid) begin
          op_d    = instr[15:13];
          wb_d    = instr[11];
          rd_d    = instr[9:8];
          a_d     = rf_q[instr[9:8]];
          b_d     = instr[12] ? instr[7:0] : rf_q[instr[1:0]];
          cnt_d   = 4'd0;
          state_d = StExec;
        end
      end
      StExec: begin
        // done is registered so it is high exactly during the WRITE cycle.
        if (cnt_q == LastCnt) begin
          state_d = StWrite;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StWrite: begin
        flags_d = {alu_v, alu_c, alu_n, alu_z};
        last_d  = alu_result;
        if (wb_q) begin
          rf_d[rd_q] = alu_result;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      op_q    <= 3'd0;
      wb_q    <= 1'b0;
      rd_q    <= 2'd0;
      done_q  <= 1'b0;
      flags_q <= 4'd0;
      last_q  <= 8'd0;
      rf_q    <= '{default: 8'd0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      wb_q    <= wb_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
      flags_q <= flags_d;
      last_q  <= last_d;
      rf_q    <= rf_d;
    end
  end

  assign instr_ready = (state_q == StIdle);
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_op      = op_q;
  assign done        = done_q;
  assign flags       = flags_q;
  assign last_result = last_q;
  assign dbg_data    = rf_q[dbg_sel];

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: bench-side ALU model, scoreboard of expected retirements,
// a second instance with ALU_LAT=1 for latency checks.
module tb_alu_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        instr_valid, instr_ready;
  logic [15:0] instr;
  logic [7:0]  alu_a, alu_b, alu_result;
  logic [2:0]  alu_op;
  logic        alu_v, alu_c, alu_n, alu_z;
  logic        done;
  logic [3:0]  flags;
  logic [7:0]  last_result, dbg_data;
  logic [1:0]  dbg_sel;

  logic        i1_valid, i1_ready;
  logic [15:0] i1_instr;
  logic [7:0]  a1, b1, res1, last1, dbg1;
  logic [2:0]  op1;
  logic        v1, c1, n1, z1, done1;
  logic [3:0]  flags1;
  logic [1:0]  dbg_sel1;

  typedef struct {
    logic [7:0] res;
    logic [3:0] flg;
    int         dcyc;
  } exp_t;

  exp_t       sb[$];
  exp_t       cur;
  bit         pend = 1'b0;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         waited;
  logic [7:0] m_rf [4];

  // Returns {V,C,N,Z,result}.
  function automatic logic [11:0] alu_f(input logic [2:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] r;
    logic       v, c;
    v = 1'b0;
    c = 1'b0;
    s = 9'd0;
    case (op)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[7:0];
        c = s[8];
        v = (a[7] == b[7]) && (r[7] != a[7]);
      end
      3'd1: begin
        s = {1'b0, a} + {1'b0, ~b} + 9'd1;
        r = s[7:0];
        c = s[8];
        v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      3'd2:    r = a & b;
      3'd3:    r = a | b;
      3'd4:    r = b;
      3'd5:    r = a ^ b;
      3'd6:    r = a;
      default: r = ~a;
    endcase
    return {v, c, r[7], (r == 8'd0), r};
  endfunction

  function automatic logic [15:0] enc(input logic [2:0] op, input logic ui, input logic wb,
                                      input logic [1:0] rd, input logic [7:0] low);
    return {op, ui, wb, 1'b0, rd, low};
  endfunction

  assign {alu_v, alu_c, alu_n, alu_z, alu_result} = alu_f(alu_op, alu_a, alu_b);
  assign {v1, c1, n1, z1, res1} = alu_f(op1, a1, b1);

  alu_sequencer #(.ALU_LAT(2)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_result  (alu_result),
    .alu_v       (alu_v),
    .alu_c       (alu_c),
    .alu_n       (alu_n),
    .alu_z       (alu_z),
    .done        (done),
    .flags       (flags),
    .last_result (last_result),
    .dbg_sel     (dbg_sel),
    .dbg_data    (dbg_data)
  );

  alu_sequencer #(.ALU_LAT(1)) u_dut1 (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (i1_valid),
    .instr_ready (i1_ready),
    .instr       (i1_instr),
    .alu_a       (a1),
    .alu_b       (b1),
    .alu_op      (op1),
    .alu_result  (res1),
    .alu_v       (v1),
    .alu_c       (c1),
    .alu_n       (n1),
    .alu_z       (z1),
    .done        (done1),
    .flags       (flags1),
    .last_result (last1),
    .dbg_sel     (dbg_sel1),
    .dbg_data    (dbg1)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Retirement monitor: pops the scoreboard on each done pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (pend) begin
        chk("last_result", last_result, cur.res);
        chk("flags", flags, cur.flg);
        pend = 1'b0;
      end
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", done, 1'b0);
        end else begin
          cur = sb.pop_front();
          chk("done_cycle", cyc, cur.dcyc);
          pend = 1'b1;
        end
      end
    end
  end

  // Called at a negedge; returns one negedge after the accepting edge.
  task automatic send(input logic [15:0] ins, output int n);
    logic [7:0]  a, b;
    logic [11:0] r;
    n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", instr_ready, 1'b1);
    instr_valid = 1'b1;
    instr = ins;
    a = m_rf[ins[9:8]];
    b = ins[12] ? ins[7:0] : m_rf[ins[1:0]];
    r = alu_f(ins[15:13], a, b);
    sb.push_back('{res: r[7:0], flg: r[11:8], dcyc: cyc + 1 + 2});
    if (ins[11]) m_rf[ins[9:8]] = r[7:0];
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while ((sb.size() != 0 || pend) && n < 40);
    chk("drain_timeout", (sb.size() == 0 && !pend), 1'b1);
  endtask

  task automatic chk_regs(input string tag);
    for (int r = 0; r < 4; r++) begin
      dbg_sel = 2'(r);
      #1;
      chk(tag, dbg_data, m_rf[r]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < 4; r++) m_rf[r] = 8'd0;
    rst = 1'b1;
    instr_valid = 1'b1;
    instr = enc(3'd4, 1'b1, 1'b1, 2'd1, 8'h55);
    dbg_sel = 2'd0;
    i1_valid = 1'b0;
    i1_instr = 16'd0;
    dbg_sel1 = 2'd0;

    // Reset with a valid instruction presented: nothing is accepted.
    repeat (3) begin
      @(negedge clk);
      chk("done_in_reset", done, 1'b0);
    end
    rst = 1'b0;
    instr_valid = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", instr_ready, 1'b1);
    chk("flags_after_reset", flags, 4'd0);
    chk("last_after_reset", last_result, 8'd0);
    chk("alu_a_reset", alu_a, 8'd0);
    chk("alu_b_reset", alu_b, 8'd0);
    chk("alu_op_reset", alu_op, 3'd0);
    chk_regs("rf_after_reset");

    // Load R0 = 0x7F; write visible one cycle after WRITE.
    @(negedge clk);
    dbg_sel = 2'd0;
    send(enc(3'd4, 1'b1, 1'b1, 2'd0, 8'h7F), waited);
    instr_valid = 1'b0;
    chk("ready_low_exec", instr_ready, 1'b0);
    repeat (2) @(negedge clk);
    chk("dbg_before_wb", dbg_data, 8'h00);
    @(negedge clk);
    chk("dbg_after_wb", dbg_data, 8'h7F);
    drain();

    // Add immediate: 0x7F + 1 overflows to 0x80.
    @(negedge clk);
    send(enc(3'd0, 1'b1, 1'b1, 2'd0, 8'h01), waited);
    instr = 16'hFFFF;
    instr_valid = 1'b0;
    chk("exec_alu_a", alu_a, 8'h7F);
    chk("exec_alu_b", alu_b, 8'h01);
    chk("exec_alu_op", alu_op, 3'd0);
    @(negedge clk);
    chk("exec_alu_b_held", alu_b, 8'h01);
    drain();
    chk_regs("rf_after_add");
    chk("add_result", last_result, 8'h80);
    chk("add_vnz", flags & 4'b1011, 4'b1010);

    // Compare R0 - R0 without writeback.
    @(negedge clk);
    send(enc(3'd1, 1'b0, 1'b0, 2'd0, 8'h00), waited);
    instr_valid = 1'b0;
    drain();
    chk("cmp_z", flags[0], 1'b1);
    chk("cmp_last", last_result, 8'h00);
    dbg_sel = 2'd0;
    #1;
    chk("cmp_r0_kept", dbg_data, 8'h80);

    // Reset in the second EXEC cycle of a write to R2 aborts it.
    @(negedge clk);
    instr_valid = 1'b1;
    instr = enc(3'd4, 1'b1, 1'b1, 2'd2, 8'h33);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int r = 0; r < 4; r++) m_rf[r] = 8'd0;
    repeat (4) begin
      @(negedge clk);
      chk("done_after_abort", done, 1'b0);
    end
    chk("flags_after_abort", flags, 4'd0);
    chk("last_after_abort", last_result, 8'd0);
    chk_regs("rf_after_abort");

    // Back-to-back with instr_valid held: ready low 3 cycles, done every 4 cycles.
    @(negedge clk);
    send(enc(3'd4, 1'b1, 1'b1, 2'd1, 8'h0F), waited);
    send(enc(3'd0, 1'b0, 1'b1, 2'd1, 8'hFD) | 16'h0400, waited);
    chk("b2b_ready_low_2", waited, 3);
    send(enc(3'd5, 1'b1, 1'b1, 2'd3, 8'hA5), waited);
    chk("b2b_ready_low_3", waited, 3);
    instr_valid = 1'b0;
    drain();
    chk_regs("rf_after_b2b");
    dbg_sel = 2'd1;
    #1;
    chk("rd_eq_rs_sum", dbg_data, 8'h1E);

    // ALU_LAT=1 instance: done at T+2.
    @(negedge clk);
    dbg_sel1 = 2'd2;
    i1_valid = 1'b1;
    i1_instr = enc(3'd4, 1'b1, 1'b1, 2'd2, 8'h5A);
    @(negedge clk);
    i1_valid = 1'b0;
    chk("lat1_done_early", done1, 1'b0);
    chk("lat1_ready_low", i1_ready, 1'b0);
    @(negedge clk);
    chk("lat1_done", done1, 1'b1);
    @(negedge clk);
    chk("lat1_done_pulse", done1, 1'b0);
    chk("lat1_last", last1, 8'h5A);
    chk("lat1_flags", flags1, 4'b0000);
    chk("lat1_ready", i1_ready, 1'b1);
    chk("lat1_rf", dbg1, 8'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle control unit for the 8-bit processor datapath. Accepts one instruction at a time over a valid/ready handshake and reads operands from an internal 4×8 register file. It drives the shared 8-bit ALU's operand and operation inputs, waits a fixed ALU latency, and then captures the result and the V/C/N/Z flags. It sits between the instruction source and the ALU and owns all register-file writes and the architectural flag register.

## Interface
- ALU_LAT, 2, cycles operands are held on the ALU before the result is sampled; legal range 1–15
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- instr_valid  input  1  instr holds a valid instruction
- instr_ready  output  1  sequencer can accept an instruction this cycle
- instr  input  16  instruction word, fields:
  - [15:13] op
  - [12] use_imm
  - [11] wb_en
  - [10] reserved
  - [9:8] rd, which is also operand A
  - [7:0] imm when use_imm=1
  - [1:0] rs when use_imm=0
- alu_a  output  8  ALU operand A
- alu_b  output  8  ALU operand B
- alu_op  output  3  ALU control code
- alu_result  input  8  ALU result
- alu_v, alu_c, alu_n, alu_z  input  1 each  ALU flags
- done  output  1  one-cycle pulse when an instruction retires
- flags  output  4  architectural {V,C,N,Z}
- last_result  output  8  result of the most recently retired instruction
- dbg_sel  input  2  register-file debug read select
- dbg_data  output  8  combinational read of register dbg_sel

## Operation
- States: IDLE, EXEC, WRITE.
- IDLE:
  - instr_ready=1.
  - On instr_valid && instr_ready, the instruction is accepted:
    - latch op, wb_en, rd.
    - latch A = R[rd].
    - latch B = use_imm ? imm : R[rs].
    - Go to EXEC with wait counter cleared.
- EXEC:
  - alu_a, alu_b and alu_op are driven from the latched values and stay stable.
  - The counter increments each cycle.
  - After ALU_LAT cycles in EXEC, go to WRITE.
- WRITE:
  - Sample alu_result and the flags.
  - flags <= {alu_v, alu_c, alu_n, alu_z}, updated regardless of wb_en.
  - last_result <= alu_result.
  - If wb_en=1, R[rd] <= alu_result.
  - done=1 for this cycle only.
  - Go to IDLE.
- instr_ready=0 in EXEC and WRITE; instr is ignored there.
- Operand latching at accept: a later change of instr, or a write to R[rd], does not alter the in-flight operands.
- Reserved bit [10]: ignored. When use_imm=0, imm[7:2] is ignored.
- op is passed to the ALU unmodified; the sequencer does not interpret it.
- wb_en=0 gives compare/test behaviour: flags and last_result update, register file unchanged.
- rd == rs is legal; both operands read the same pre-instruction value.
- Register file:
  - Write is synchronous.
  - dbg_data is a combinational read and reflects a write from the cycle after WRITE.
- alu_a, alu_b and alu_op outside EXEC: hold their last driven values; after reset they are 0.

## Timing
- Reset values:
  - state=IDLE, instr_ready=1, done=0.
  - flags=4'b0000, last_result=0.
  - alu_a=alu_b=0, alu_op=0.
  - R0–R3=0, wait counter=0.
- Accept in cycle T:
  - EXEC spans T+1 … T+ALU_LAT.
  - WRITE and done occur in T+ALU_LAT+1.
  - instr_ready is high again in T+ALU_LAT+2.
- Throughput: one instruction per ALU_LAT+2 cycles when instr_valid is held high.
- The ALU must present a settled result within ALU_LAT cycles of its operands changing. ALU_LAT is set to the ALU's latency in clk cycles.
- rst is sampled every cycle and overrides all state:
  - Reset during EXEC or WRITE aborts the instruction: no register write, flags cleared, done stays 0.
  - An instruction presented in the same cycle as rst is not accepted.

## Test plan
- Reset with instr_valid=1 -> no accept. After release:
  - instr_ready=1, flags=0, R0–R3=0.
  - done is never high in the reset cycle.
- Load R0 with op=4 (pass B), use_imm=1, imm=0x7F, wb_en=1 -> done at T+3 (ALU_LAT=2); dbg_sel=0 then reads 0x7F at T+4.
- Add immediate, R0=0x7F:
  - Stimulus: op=0, use_imm=1, imm=0x01, wb_en=1.
  - Response: R0=0x80, last_result=0x80, flags V=1, N=1, Z=0.
- Compare, R0=0x80:
  - Stimulus: op=1 (subtract), rs=R0 via use_imm=0, rd=0, wb_en=0.
  - Response: flags Z=1, R0 remains 0x80, last_result=0x00.
- instr_valid held high for 3 instructions, ALU_LAT=2 -> done pulses exactly 4 cycles apart; instr_ready low for 3 cycles after each accept.
- rst asserted in the second EXEC cycle of a wb_en=1 write to R2 -> R2 stays 0, done never asserts, flags=0. Repeat the test run with ALU_LAT=1: done at T+2.
